// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared definitions for the UART transmit stage: frame-length
//               encodings, TX FSM state type, status word and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

  localparam int         c_word_w      = 9;

  // One-hot data-length encodings as written by the CSR block
  localparam logic [4:0] c_frame_len_5 = 5'b00001;
  localparam logic [4:0] c_frame_len_6 = 5'b00010;
  localparam logic [4:0] c_frame_len_7 = 5'b00100;
  localparam logic [4:0] c_frame_len_8 = 5'b01000;
  localparam logic [4:0] c_frame_len_9 = 5'b10000;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } TXState_t;

  // Status bits as packed by the CSR block into TXStatus
  typedef struct packed {
    logic overflow;
    logic full;
    logic empty;
    logic busy;
  } TXStatus_t;

  // Number of data bits for a frame-length code; anything not one-hot means 5
  function automatic logic [3:0] frame_bits(input logic [4:0] frame_len);
    case (frame_len)
      c_frame_len_6: frame_bits = 4'd6;
      c_frame_len_7: frame_bits = 4'd7;
      c_frame_len_8: frame_bits = 4'd8;
      c_frame_len_9: frame_bits = 4'd9;
      default:       frame_bits = 4'd5;
    endcase
  endfunction

  // Mask selecting the low nbits bits of a word
  function automatic logic [c_word_w-1:0] data_mask(input logic [3:0] nbits);
    for (int i = 0; i < c_word_w; i++) begin
      data_mask[i] = (i < int'(nbits));
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_if
// Description : Word push handshake between the CSR TXDATA strobe and the
//               UART transmit stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if;
  import uart_tx_pkg::*;

  logic [c_word_w-1:0] d;
  logic                d_valid;
  logic                d_ready;

  modport master (output d, output d_valid, input  d_ready);
  modport slave  (input  d, input  d_valid, output d_ready);

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : DEPTH x WIDTH synchronous FIFO with wrap-bit pointers and
//               combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     push_i,
  input  wire logic [WIDTH-1:0]         wdata_i,
  input  wire logic                     pop_i,
  output logic      [WIDTH-1:0]         rdata_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic      [$clog2(DEPTH):0]   level_o
);

  localparam int c_aw = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i & ~empty_o;

  // Pointers advance on accepted push/pop; reset discards all contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= wdata_i;
  end

  assign rdata_o = r_mem[r_rd_ptr[c_aw-1:0]];
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign level_o = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmit stage. Buffers words in a FIFO and serialises
//               them as start / data (LSB first) / optional parity / 1-2 stop.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 32
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  input  wire logic                          enable_i,
  input  wire logic [DIV_W-1:0]              divider_i,
  input  wire logic [4:0]                    frame_len_i,
  input  wire logic                          parity_en_i,
  input  wire logic                          parity_odd_i,
  input  wire logic                          stop2_i,
  uart_tx_if.slave                           d_if,
  output logic                               tx_o,
  output logic                               busy_o,
  output logic                               fifo_empty_o,
  output logic                               fifo_full_o,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level_o,
  output logic                               overflow_o,
  input  wire logic                          overflow_clr_i,
  output logic                               done_o
);

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [c_word_w-1:0] w_head;

  // Registered frame state
  TXState_t            r_state;
  logic [DIV_W-1:0]    r_cnt;
  logic [DIV_W-1:0]    r_period_m1;
  logic [c_word_w-1:0] r_shift;
  logic [3:0]          r_bit_idx;
  logic [3:0]          r_nbits;
  logic                r_par_en;
  logic                r_par_bit;
  logic                r_stop2;
  logic                r_stop_idx;
  logic                r_tx;
  logic                r_overflow;

  // Next-state values
  TXState_t            w_state_nxt;
  logic [DIV_W-1:0]    w_cnt_nxt;
  logic [DIV_W-1:0]    w_period_nxt;
  logic [c_word_w-1:0] w_shift_nxt;
  logic [3:0]          w_bit_idx_nxt;
  logic [3:0]          w_nbits_nxt;
  logic                w_par_en_nxt;
  logic                w_par_bit_nxt;
  logic                w_stop2_nxt;
  logic                w_stop_idx_nxt;
  logic                w_tx_nxt;
  logic                w_load;
  logic                w_done;

  // Frame parameters sampled from the live configuration at pop time
  logic [DIV_W-1:0]    w_period_m1;
  logic [3:0]          w_nbits;
  logic                w_parity;
  logic                w_bit_end;
  logic                w_can_start;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (c_word_w)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .wdata_i (d_if.d),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .empty_o (w_empty),
    .full_o  (w_full),
    .level_o (fifo_level_o)
  );

  assign w_push      = d_if.d_valid & ~w_full;
  assign d_if.d_ready = ~w_full;

  assign w_period_m1 = (divider_i == '0) ? '0 : divider_i - DIV_W'(1);
  assign w_nbits     = frame_bits(frame_len_i);
  assign w_parity    = (^(w_head & data_mask(w_nbits))) ^ parity_odd_i;
  assign w_bit_end   = (r_cnt == '0);
  assign w_can_start = enable_i & ~w_empty;

  // FSM next-state, bit timing and serial line value
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_period_nxt   = r_period_m1;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_nbits_nxt    = r_nbits;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_stop2_nxt    = r_stop2;
    w_stop_idx_nxt = r_stop_idx;
    w_tx_nxt       = r_tx;
    w_load         = 1'b0;
    w_done         = 1'b0;
    w_pop          = 1'b0;

    if (r_state != TX_IDLE && !w_bit_end) begin
      w_cnt_nxt = r_cnt - DIV_W'(1);
    end

    case (r_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_can_start) w_load = 1'b1;
      end
      TX_START: begin
        if (w_bit_end) begin
          w_state_nxt   = TX_DATA;
          w_tx_nxt      = r_shift[0];
          w_cnt_nxt     = r_period_m1;
          w_bit_idx_nxt = 4'd0;
        end
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_cnt_nxt = r_period_m1;
          if (r_bit_idx == (r_nbits - 4'd1)) begin
            if (r_par_en) begin
              w_state_nxt = TX_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt    = TX_STOP;
              w_tx_nxt       = 1'b1;
              w_stop_idx_nxt = 1'b0;
            end
          end else begin
            w_bit_idx_nxt = r_bit_idx + 4'd1;
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = TX_STOP;
          w_tx_nxt       = 1'b1;
          w_cnt_nxt      = r_period_m1;
          w_stop_idx_nxt = 1'b0;
        end
      end
      TX_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_idx) begin
            w_stop_idx_nxt = 1'b1;
            w_cnt_nxt      = r_period_m1;
          end else begin
            w_done = 1'b1;
            if (w_can_start) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = TX_IDLE;
              w_tx_nxt    = 1'b1;
            end
          end
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Pop the head word and freeze its configuration for the whole frame
    if (w_load) begin
      w_pop         = 1'b1;
      w_state_nxt   = TX_START;
      w_tx_nxt      = 1'b0;
      w_cnt_nxt     = w_period_m1;
      w_period_nxt  = w_period_m1;
      w_shift_nxt   = w_head;
      w_nbits_nxt   = w_nbits;
      w_par_en_nxt  = parity_en_i;
      w_par_bit_nxt = w_parity;
      w_stop2_nxt   = stop2_i;
    end
  end

  // State and datapath registers; reset parks the line high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= TX_IDLE;
      r_cnt       <= '0;
      r_period_m1 <= '0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_nbits     <= 4'd5;
      r_par_en    <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop2     <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_period_m1 <= w_period_nxt;
      r_shift     <= w_shift_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_nbits     <= w_nbits_nxt;
      r_par_en    <= w_par_en_nxt;
      r_par_bit   <= w_par_bit_nxt;
      r_stop2     <= w_stop2_nxt;
      r_stop_idx  <= w_stop_idx_nxt;
      r_tx        <= w_tx_nxt;
    end
  end

  // Sticky overflow; a clear wins over a same-cycle set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (overflow_clr_i) begin
      r_overflow <= 1'b0;
    end else if (d_if.d_valid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign tx_o         = r_tx;
  assign busy_o       = (r_state != TX_IDLE);
  assign fifo_empty_o = w_empty;
  assign fifo_full_o  = w_full;
  assign overflow_o   = r_overflow;
  assign done_o       = w_done;

endmodule
`default_nettype wire
